// File: rtl/snake_updater_pkg.sv
// Shared definitions for the snake move updater: FSM states, cell and key
// codes, and LFSR constants.
package snake_updater_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_EVAL,
        ST_MOVE,
        ST_FOOD,
        ST_OVER
    } state_e;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SNAKE = 2'b01,
        CELL_FOOD  = 2'b10
    } cell_e;

    // Reverse of a direction is its bitwise complement.
    typedef enum logic [1:0] {
        KEY_W = 2'b00,  // up,    y-1
        KEY_A = 2'b01,  // left,  x-1
        KEY_D = 2'b10,  // right, x+1
        KEY_S = 2'b11   // down,  y+1
    } key_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (register bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [15:0] SEG_EMPTY = 16'hFFFF;

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick food candidate cells.
module snake_lfsr16
    import snake_updater_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    // Shift left, feeding back the XOR of the tapped bits.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // Advance every cycle; reseed on synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/snake_updater.sv
// Snake game state updater: latches a move, asks the checker for a verdict,
// shifts the body, and places new food by probing from a random cell.
module snake_updater
    import snake_updater_pkg::*;
#(
    parameter int unsigned SIZE_X = 10,
    parameter int unsigned SIZE_Y = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic [1:0]                   key,
    input  logic                         dead,
    input  logic                         grow,
    output logic                         check,
    output logic [1:0]                   key_out,
    output logic [16*SIZE_X*SIZE_Y-1:0]  snake_xy,
    output logic [2*SIZE_X*SIZE_Y-1:0]   field,
    output logic [15:0]                  length,
    output logic                         busy,
    output logic                         game_over
);

    localparam int unsigned   NCELL     = SIZE_X * SIZE_Y;
    localparam int unsigned   CW        = $clog2(NCELL);
    localparam logic [15:0]   NCELL16   = 16'(NCELL);
    localparam logic [CW-1:0] LAST_CELL = CW'(NCELL - 1);
    localparam int unsigned   HOME_LIN  = (SIZE_Y / 2) * SIZE_X + SIZE_X / 2;

    state_e        state_q, state_d;
    logic [1:0]    key_out_q, key_out_d;
    logic [1:0]    dir_q, dir_d;
    logic [15:0]   len_q, len_d;
    logic          grow_q, grow_d;
    logic [CW-1:0] cand_q, cand_d;
    logic          start_q, start_d;
    logic [15:0]   seg_q   [NCELL];
    logic [15:0]   seg_d   [NCELL];
    logic [1:0]    field_q [NCELL];
    logic [1:0]    field_d [NCELL];

    logic [15:0]   lfsr;
    logic [7:0]    hx, hy, nx, ny;
    logic [15:0]   tail_seg;
    int unsigned   head_lin, tail_lin;
    logic          head_ok;
    logic [CW-1:0] head_cell, tail_cell, probe;

    snake_lfsr16 u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst),
        .lfsr_o (lfsr)
    );

    // Next head position, tail cell, and current food probe cell.
    always_comb begin
        hx = seg_q[0][7:0];
        hy = seg_q[0][15:8];
        nx = hx;
        ny = hy;
        case (key_out_q)
            KEY_W:   ny = hy - 8'd1;
            KEY_A:   nx = hx - 8'd1;
            KEY_S:   ny = hy + 8'd1;
            default: nx = hx + 8'd1;
        endcase
        head_lin  = 32'(ny) * SIZE_X + 32'(nx);
        head_ok   = head_lin < NCELL;
        head_cell = CW'(head_lin);
        tail_seg  = seg_q[CW'(len_q - 16'd1)];
        tail_lin  = 32'(tail_seg[15:8]) * SIZE_X + 32'(tail_seg[7:0]);
        tail_cell = CW'(tail_lin);
        // First FOOD cycle takes its candidate straight from the LFSR.
        probe     = start_q ? CW'(lfsr % NCELL16) : cand_q;
    end

    // FSM next state and datapath updates.
    always_comb begin
        state_d   = state_q;
        key_out_d = key_out_q;
        dir_d     = dir_q;
        len_d     = len_q;
        grow_d    = grow_q;
        cand_d    = cand_q;
        start_d   = 1'b0;
        seg_d     = seg_q;
        field_d   = field_q;
        case (state_q)
            ST_IDLE: begin
                if (step) begin
                    key_out_d = (len_q > 16'd1 && key == ~dir_q) ? dir_q : key;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_EVAL;
            ST_EVAL: begin
                grow_d  = grow;
                state_d = dead ? ST_OVER : ST_MOVE;
            end
            ST_MOVE: begin
                dir_d = key_out_q;
                if (grow_q) len_d = len_q + 16'd1;
                for (int unsigned i = 1; i < NCELL; i++) begin
                    seg_d[i] = (i < 32'(len_d)) ? seg_q[i-1] : SEG_EMPTY;
                end
                seg_d[0] = {ny, nx};
                // Tail is cleared before the head is drawn so a head moving
                // into the vacated tail cell leaves it marked as snake.
                if (!grow_q) field_d[tail_cell] = CELL_EMPTY;
                if (head_ok) field_d[head_cell] = CELL_SNAKE;
                if (grow_q) begin
                    state_d = ST_FOOD;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FOOD: begin
                if (len_q == NCELL16) begin
                    state_d = ST_OVER;
                end else if (field_q[probe] == CELL_EMPTY) begin
                    field_d[probe] = CELL_FOOD;
                    state_d        = ST_IDLE;
                end else begin
                    cand_d = (probe == LAST_CELL) ? '0 : probe + 1'b1;
                end
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            key_out_q <= KEY_D;
            dir_q     <= KEY_D;
            len_q     <= 16'd1;
            grow_q    <= 1'b0;
            cand_q    <= '0;
            start_q   <= 1'b0;
            for (int unsigned i = 0; i < NCELL; i++) begin
                seg_q[i]   <= SEG_EMPTY;
                field_q[i] <= CELL_EMPTY;
            end
            seg_q[0]               <= {8'(SIZE_Y / 2), 8'(SIZE_X / 2)};
            field_q[CW'(HOME_LIN)] <= CELL_SNAKE;
            field_q[0]             <= CELL_FOOD;
        end else begin
            state_q   <= state_d;
            key_out_q <= key_out_d;
            dir_q     <= dir_d;
            len_q     <= len_d;
            grow_q    <= grow_d;
            cand_q    <= cand_d;
            start_q   <= start_d;
            seg_q     <= seg_d;
            field_q   <= field_d;
        end
    end

    // Flatten segment and field arrays onto the output buses.
    always_comb begin
        for (int unsigned k = 0; k < NCELL; k++) begin
            snake_xy[16*k +: 16] = seg_q[k];
            field[2*k +: 2]      = field_q[k];
        end
    end

    assign check     = (state_q == ST_CHECK);
    assign key_out   = key_out_q;
    assign length    = len_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_OVER);
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_snake_updater.sv
// Randomized bench for snake_updater against a queue-based game model.
`timescale 1ns/1ps
module tb_snake_updater;

    localparam int SX = 10;
    localparam int SY = 10;
    localparam int N  = SX * SY;

    logic              clk = 1'b0;
    logic              rst, step, dead, grow;
    logic [1:0]        key, key_out;
    logic              check, busy, game_over;
    logic [16*N-1:0]   snake_xy, exp_xy;
    logic [2*N-1:0]    field, exp_field;
    logic [15:0]       length;
    logic [15:0]       lfsr_m;

    int n_tests = 0;
    int n_fail  = 0;

    // Game model: body as coordinate queues (head first) and a cell map.
    int         sx[$];
    int         sy[$];
    int         mf[N];
    logic [1:0] m_dir, m_key;
    bit         m_over;

    snake_updater #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
        .clk(clk), .rst(rst), .step(step), .key(key), .dead(dead), .grow(grow),
        .check(check), .key_out(key_out), .snake_xy(snake_xy), .field(field),
        .length(length), .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) lfsr_m <= !rst ? 16'hACE1 : lfsr_next(lfsr_m);

    // Candidate seen in the first FOOD cycle if step is driven now.
    function automatic int pred_cand();
        logic [15:0] v = lfsr_m;
        for (int i = 0; i < 4; i++) v = lfsr_next(v);
        return int'(v) % N;
    endfunction

    function automatic logic [1:0] eff_dir(input logic [1:0] k);
        return (sx.size() > 1 && k == ~m_dir) ? m_dir : k;
    endfunction

    function automatic bit move_ok(input logic [1:0] k);
        int x = sx[0];
        int y = sy[0];
        case (eff_dir(k))
            2'b00: y--;
            2'b01: x--;
            2'b11: y++;
            default: x++;
        endcase
        if (x < 0 || y < 0 || x >= SX || y >= SY) return 1'b0;
        return mf[y*SX + x] != 1;
    endfunction

    function automatic void model_reset();
        sx = {SX / 2};
        sy = {SY / 2};
        foreach (mf[c]) mf[c] = 0;
        mf[(SY/2)*SX + SX/2] = 1;
        mf[0]  = 2;
        m_dir  = 2'b10;
        m_key  = 2'b10;
        m_over = 1'b0;
    endfunction

    // Apply one move; returns cycles from step until busy drops.
    function automatic int model_step(input logic [1:0] k, input bit d, input bit g, input int cand);
        int hx, hy, tx, ty, c, p;
        m_key = eff_dir(k);
        if (d) begin
            m_over = 1'b1;
            return 3;
        end
        hx = sx[0];
        hy = sy[0];
        case (m_key)
            2'b00: hy--;
            2'b01: hx--;
            2'b11: hy++;
            default: hx++;
        endcase
        tx = sx[sx.size()-1];
        ty = sy[sy.size()-1];
        sx.push_front(hx);
        sy.push_front(hy);
        if (!g) begin
            void'(sx.pop_back());
            void'(sy.pop_back());
            mf[ty*SX + tx] = 0;
        end
        mf[hy*SX + hx] = 1;
        m_dir = m_key;
        if (!g) return 4;
        if (sx.size() == N) begin
            m_over = 1'b1;
            return 5;
        end
        c = cand;
        p = 0;
        while (mf[c] != 0) begin
            c = (c + 1) % N;
            p++;
        end
        mf[c] = 2;
        return 5 + p;
    endfunction

    function automatic void build_expect();
        exp_xy = '1;
        for (int k = 0; k < sx.size(); k++) exp_xy[16*k +: 16] = {8'(sy[k]), 8'(sx[k])};
        for (int c = 0; c < N; c++) exp_field[2*c +: 2] = 2'(mf[c]);
    endfunction

    function automatic int first_seg_diff();
        for (int k = 0; k < N; k++) if (snake_xy[16*k +: 16] !== exp_xy[16*k +: 16]) return k;
        return -1;
    endfunction

    function automatic int first_cell_diff();
        for (int c = 0; c < N; c++) if (field[2*c +: 2] !== exp_field[2*c +: 2]) return c;
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; step = 1'b0; dead = 1'b0; grow = 1'b0; key = 2'b10;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Wait until a step issued now would start FOOD on the target cell.
    task automatic wait_cand(input int target, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 5000; w++) begin
            if (pred_cand() == target) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // One full transaction, called at a negedge with the DUT idle.
    task automatic do_step(input logic [1:0] k, input bit d, input bit g);
        int lat, cyc, idx;
        lat  = model_step(k, d, g, pred_cand());
        step = 1'b1; key = k; dead = d; grow = g;
        @(negedge clk);
        step = 1'b0;
        n_tests++;
        if (check !== 1'b1) begin n_fail++; $display("FAIL check_pulse: got %b exp 1", check); end
        n_tests++;
        if (key_out !== m_key) begin n_fail++; $display("FAIL key_out: got %b exp %b", key_out, m_key); end
        @(negedge clk);
        cyc = 2;
        n_tests++;
        if (check !== 1'b0) begin n_fail++; $display("FAIL check_width: got %b exp 0", check); end
        while (busy === 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc != lat) begin n_fail++; $display("FAIL latency: got %0d exp %0d cycles", cyc, lat); end
        build_expect();
        n_tests++;
        if (length !== 16'(sx.size())) begin n_fail++; $display("FAIL length: got %0d exp %0d", length, sx.size()); end
        n_tests++;
        if (game_over !== m_over) begin n_fail++; $display("FAIL game_over: got %b exp %b", game_over, m_over); end
        n_tests++;
        if (snake_xy !== exp_xy) begin
            n_fail++; idx = first_seg_diff();
            $display("FAIL snake_xy seg %0d: got %h exp %h", idx, snake_xy[16*idx +: 16], exp_xy[16*idx +: 16]);
        end
        n_tests++;
        if (field !== exp_field) begin
            n_fail++; idx = first_cell_diff();
            $display("FAIL field cell %0d: got %b exp %b", idx, field[2*idx +: 2], exp_field[2*idx +: 2]);
        end
    endtask

    task automatic test_reset();
        int idx;
        apply_reset();
        build_expect();
        n_tests++;
        if ({busy, game_over, check} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {busy, game_over, check}); end
        n_tests++;
        if (key_out !== 2'b10) begin n_fail++; $display("FAIL reset_key_out: got %b exp 10", key_out); end
        n_tests++;
        if (length !== 16'd1) begin n_fail++; $display("FAIL reset_length: got %0d exp 1", length); end
        n_tests++;
        if (snake_xy !== exp_xy) begin
            n_fail++; idx = first_seg_diff();
            $display("FAIL reset_snake_xy seg %0d: got %h exp %h", idx, snake_xy[16*idx +: 16], exp_xy[16*idx +: 16]);
        end
        n_tests++;
        if (field !== exp_field) begin
            n_fail++; idx = first_cell_diff();
            $display("FAIL reset_field cell %0d: got %b exp %b", idx, field[2*idx +: 2], exp_field[2*idx +: 2]);
        end
    endtask

    task automatic test_first_move();
        apply_reset();
        do_step(2'b10, 1'b0, 1'b0);
        n_tests++;
        if (snake_xy[15:0] !== 16'h0506) begin n_fail++; $display("FAIL first_head: got %h exp 0506", snake_xy[15:0]); end
        n_tests++;
        if ({field[111:110], field[113:112]} !== 4'b0001) begin
            n_fail++; $display("FAIL first_cells: got 55=%b 56=%b exp 00 01", field[111:110], field[113:112]);
        end
    endtask

    task automatic test_grow_and_reverse();
        int nfood;
        apply_reset();
        do_step(2'b10, 1'b0, 1'b1);
        n_tests++;
        if (length !== 16'd2 || snake_xy[31:16] !== 16'h0505) begin
            n_fail++; $display("FAIL grow: got len %0d seg1 %h exp len 2 seg1 0505", length, snake_xy[31:16]);
        end
        nfood = 0;
        for (int c = 0; c < N; c++) if (field[2*c +: 2] === 2'b10) nfood++;
        n_tests++;
        if (nfood != 2) begin n_fail++; $display("FAIL food_count: got %0d exp 2", nfood); end
        do_step(2'b01, 1'b0, 1'b0);
        n_tests++;
        if (key_out !== 2'b10 || snake_xy[15:0] !== 16'h0507) begin
            n_fail++; $display("FAIL reversal: got key_out %b head %h exp 10 0507", key_out, snake_xy[15:0]);
        end
    endtask

    task automatic test_dead();
        logic [2*N-1:0] f0;
        apply_reset();
        f0 = field;
        do_step(2'b11, 1'b1, 1'b1);
        n_tests++;
        if (field !== f0) begin n_fail++; $display("FAIL dead_field: got changed field exp unchanged"); end
        step = 1'b1; key = 2'b01; dead = 1'b0; grow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({check, busy, game_over} !== 3'b001) begin
                n_fail++; $display("FAIL over_absorb cyc %0d: got %b exp 001", i, {check, busy, game_over});
            end
        end
        step = 1'b0;
        build_expect();
        n_tests++;
        if (snake_xy !== exp_xy || field !== exp_field) begin n_fail++; $display("FAIL over_frozen: got changed state exp frozen"); end
    endtask

    task automatic test_probe_wrap();
        bit ok;
        int targets[3] = '{56, 99, 99};
        int want[3]    = '{57, 99, 1};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            wait_cand(targets[i], ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL cand_search %0d: got no match exp candidate %0d", i, targets[i]);
            end else begin
                do_step(2'b10, 1'b0, 1'b1);
                n_tests++;
                if (field[2*want[i] +: 2] !== 2'b10) begin
                    n_fail++; $display("FAIL probe %0d: got cell %0d=%b exp 10", i, want[i], field[2*want[i] +: 2]);
                end
            end
        end
    endtask

    task automatic test_reset_in_food();
        int idx;
        apply_reset();
        step = 1'b1; key = 2'b10; grow = 1'b1; dead = 1'b0;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL food_busy: got %b exp 1", busy); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        build_expect();
        n_tests++;
        if ({busy, game_over, check, key_out, length} !== {3'b000, 2'b10, 16'd1}) begin
            n_fail++; $display("FAIL food_reset_ctl: got busy %b over %b chk %b key %b len %0d exp 0 0 0 10 1",
                               busy, game_over, check, key_out, length);
        end
        n_tests++;
        if (snake_xy !== exp_xy || field !== exp_field) begin
            n_fail++; idx = first_cell_diff();
            $display("FAIL food_reset_state: first cell diff %0d seg diff %0d", idx, first_seg_diff());
        end
        do_step(2'b10, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [11:0] got;
        int idx;
        apply_reset();
        step = 1'b1; key = 2'b10; dead = 1'b0; grow = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            got[i] = check;
        end
        step = 1'b0;
        for (int i = 0; i < 3; i++) void'(model_step(2'b10, 1'b0, 1'b0, 0));
        build_expect();
        n_tests++;
        if (got !== 12'b0001_0001_0001) begin n_fail++; $display("FAIL b2b_checks: got %b exp 000100010001", got); end
        n_tests++;
        if (snake_xy !== exp_xy || field !== exp_field) begin
            n_fail++; idx = first_seg_diff();
            $display("FAIL b2b_state: seg %0d got %h", idx, snake_xy[15:0]);
        end
    endtask

    task automatic test_random();
        logic [1:0] k;
        bit found;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            found = 1'b0;
            for (int t = 0; t < 16 && !found; t++) begin
                k = 2'($urandom_range(0, 3));
                found = move_ok(k);
            end
            if (!found) break;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_step(k, 1'b0, $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; step = 1'b0; dead = 1'b0; grow = 1'b0; key = 2'b10;
        test_reset();
        test_first_move();
        test_grow_and_reverse();
        test_dead();
        test_probe_wrap();
        test_reset_in_food();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
